// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Brief    : Pipeline stage register with flush/bubble/advance/hold control,
//             multi-cycle carry return path, bubble and hold statistics.
//  Revision : 1.0  initial release
// ============================================================================

module pipe_stage_reg #(
    parameter int PAYLOAD_W = 128,
    parameter int CARRY_W   = 64,
    parameter int CNT_W     = 2,
    parameter int STALL_W   = 6,
    parameter int STAGE     = 3,
    parameter int HOLD_MAX  = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [STALL_W-1:0]              stall,
    input  logic                            flush,
    input  logic                            in_valid,
    input  logic [PAYLOAD_W-1:0]            in_payload,
    input  logic [CARRY_W-1:0]              carry_i,
    input  logic [CNT_W-1:0]                cnt_i,
    output logic                            out_valid,
    output logic [PAYLOAD_W-1:0]            out_payload,
    output logic [CARRY_W-1:0]              carry_o,
    output logic [CNT_W-1:0]                cnt_o,
    output logic [15:0]                     bubble_cnt,
    output logic [$clog2(HOLD_MAX+1)-1:0]   hold_cnt,
    output logic                            hold_overflow
);

    localparam int                  C_HOLD_W     = $clog2(HOLD_MAX + 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_MAX   = C_HOLD_W'(HOLD_MAX);
    localparam logic [15:0]         C_BUBBLE_MAX = 16'hFFFF;

    generate
        if ((STAGE < 0) || (STAGE + 1 >= STALL_W)) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
        end
        if (HOLD_MAX < 1) begin : g_bad_hold_max
            $error("pipe_stage_reg: HOLD_MAX must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_FLUSH   = 2'd0,
        MODE_BUBBLE  = 2'd1,
        MODE_ADVANCE = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_t;

    mode_t                  w_mode;
    logic                   w_up_stall;
    logic                   w_dn_stall;
    logic                   w_stall_unused;
    logic [C_HOLD_W-1:0]    w_hold_next;
    logic [15:0]            w_bubble_next;

    logic                   r_valid;
    logic [PAYLOAD_W-1:0]   r_payload;
    logic [CARRY_W-1:0]     r_carry;
    logic [CNT_W-1:0]       r_cnt;
    logic [15:0]            r_bubble_cnt;
    logic [C_HOLD_W-1:0]    r_hold_cnt;
    logic                   r_hold_overflow;

    // Only our own bit and the downstream neighbour matter; the rest of the
    // vector belongs to other stages.
    assign w_up_stall     = stall[STAGE];
    assign w_dn_stall     = stall[STAGE+1];
    assign w_stall_unused = ^stall;

    always_comb begin
        w_mode = MODE_HOLD;
        if (flush) begin
            w_mode = MODE_FLUSH;
        end else if (w_up_stall && !w_dn_stall) begin
            w_mode = MODE_BUBBLE;
        end else if (!w_up_stall) begin
            w_mode = MODE_ADVANCE;
        end
    end

    assign w_hold_next   = (r_hold_cnt == C_HOLD_MAX) ? r_hold_cnt
                                                      : r_hold_cnt + C_HOLD_W'(1);
    assign w_bubble_next = (r_bubble_cnt == C_BUBBLE_MAX) ? r_bubble_cnt
                                                          : r_bubble_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid         <= 1'b0;
            r_payload       <= '0;
            r_carry         <= '0;
            r_cnt           <= '0;
            r_bubble_cnt    <= '0;
            r_hold_cnt      <= '0;
            r_hold_overflow <= 1'b0;
        end else begin
            case (w_mode)
                MODE_FLUSH: begin
                    r_valid    <= 1'b0;
                    r_payload  <= '0;
                    r_carry    <= '0;
                    r_cnt      <= '0;
                    r_hold_cnt <= '0;
                end
                MODE_BUBBLE: begin
                    // Emit a NOP downstream while the upstream multi-cycle
                    // op keeps its partial state looping through us.
                    r_valid      <= 1'b0;
                    r_payload    <= '0;
                    r_carry      <= carry_i;
                    r_cnt        <= cnt_i;
                    r_bubble_cnt <= w_bubble_next;
                    r_hold_cnt   <= '0;
                end
                MODE_ADVANCE: begin
                    r_valid    <= in_valid;
                    r_payload  <= in_payload;
                    r_carry    <= '0;
                    r_cnt      <= '0;
                    r_hold_cnt <= '0;
                end
                default: begin
                    r_carry    <= carry_i;
                    r_cnt      <= cnt_i;
                    r_hold_cnt <= w_hold_next;
                    if (w_hold_next == C_HOLD_MAX) begin
                        r_hold_overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_valid     = r_valid;
    assign out_payload   = r_payload;
    assign carry_o       = r_carry;
    assign cnt_o         = r_cnt;
    assign bubble_cnt    = r_bubble_cnt;
    assign hold_cnt      = r_hold_cnt;
    assign hold_overflow = r_hold_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Brief    : Directed self-checking bench for pipe_stage_reg (HOLD_MAX = 4).
//  Revision : 1.0  initial release
// ============================================================================

module tb_pipe_stage_reg;

    localparam int PAYLOAD_W = 128;
    localparam int CARRY_W   = 64;
    localparam int CNT_W     = 2;
    localparam int STALL_W   = 6;
    localparam int HOLD_MAX  = 4;
    localparam int HOLD_W    = $clog2(HOLD_MAX + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [STALL_W-1:0]    stall;
    logic                  flush;
    logic                  in_valid;
    logic [PAYLOAD_W-1:0]  in_payload;
    logic [CARRY_W-1:0]    carry_i;
    logic [CNT_W-1:0]      cnt_i;
    logic                  out_valid;
    logic [PAYLOAD_W-1:0]  out_payload;
    logic [CARRY_W-1:0]    carry_o;
    logic [CNT_W-1:0]      cnt_o;
    logic [15:0]           bubble_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  hold_overflow;

    int n_vec = 0;
    int n_bad = 0;

    pipe_stage_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .CARRY_W   (CARRY_W),
        .CNT_W     (CNT_W),
        .STALL_W   (STALL_W),
        .STAGE     (3),
        .HOLD_MAX  (HOLD_MAX)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_payload    (in_payload),
        .carry_i       (carry_i),
        .cnt_i         (cnt_i),
        .out_valid     (out_valid),
        .out_payload   (out_payload),
        .carry_o       (carry_o),
        .cnt_o         (cnt_o),
        .bubble_cnt    (bubble_cnt),
        .hold_cnt      (hold_cnt),
        .hold_overflow (hold_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    localparam logic [PAYLOAD_W-1:0] P_A5 = 128'hC0DE_0000_0000_0000_0000_0000_0000_00A5;

    initial begin
        rst        = 1'b1;
        stall      = '0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_payload = 128'hFFFF;
        carry_i    = 64'hDEAD;
        cnt_i      = 2'd3;
        tick();
        tick();
        check("rst_valid",   out_valid,     1'b0);
        check("rst_payload", out_payload,   128'h0);
        check("rst_carry",   carry_o,       64'h0);
        check("rst_cnt",     cnt_o,         2'd0);
        check("rst_bubble",  bubble_cnt,    16'd0);
        check("rst_hold",    hold_cnt,      3'd0);
        check("rst_ovf",     hold_overflow, 1'b0);

        rst        = 1'b0;
        in_valid   = 1'b1;
        in_payload = P_A5;
        carry_i    = 64'hFFFF;
        cnt_i      = 2'd3;
        tick();
        check("adv_valid",   out_valid,   1'b1);
        check("adv_payload", out_payload, P_A5);
        check("adv_carry",   carry_o,     64'h0);
        check("adv_cnt",     cnt_o,       2'd0);

        stall      = 6'b001000;
        carry_i    = 64'h1234;
        cnt_i      = 2'd1;
        in_payload = 128'h4444;
        tick();
        check("bub_valid",   out_valid,   1'b0);
        check("bub_payload", out_payload, 128'h0);
        check("bub_carry",   carry_o,     64'h1234);
        check("bub_cnt",     cnt_o,       2'd1);
        check("bub_bubble",  bubble_cnt,  16'd1);

        stall      = 6'b000000;
        in_valid   = 1'b0;
        in_payload = 128'h55;
        tick();
        check("adv0_valid",   out_valid,   1'b0);
        check("adv0_payload", out_payload, 128'h55);
        check("adv0_carry",   carry_o,     64'h0);
        check("adv0_cnt",     cnt_o,       2'd0);
        check("adv0_bubble",  bubble_cnt,  16'd1);

        in_valid   = 1'b1;
        in_payload = 128'h77;
        tick();
        check("pre_hold_payload", out_payload, 128'h77);
        stall      = 6'b011000;
        in_payload = 128'h99;
        carry_i    = 64'hABC;
        cnt_i      = 2'd2;
        tick();
        tick();
        tick();
        check("hold_payload", out_payload,   128'h77);
        check("hold_valid",   out_valid,     1'b1);
        check("hold_cnt3",    hold_cnt,      3'd3);
        check("hold_carry",   carry_o,       64'hABC);
        check("hold_cntret",  cnt_o,         2'd2);
        check("hold_ovf0",    hold_overflow, 1'b0);
        check("hold_bubble",  bubble_cnt,    16'd1);
        stall = 6'b000000;
        tick();
        check("rel_payload", out_payload, 128'h99);
        check("rel_hold",    hold_cnt,    3'd0);
        check("rel_carry",   carry_o,     64'h0);

        stall      = 6'b100111;
        in_payload = 128'h1111;
        tick();
        check("ign_adv_payload", out_payload, 128'h1111);
        check("ign_adv_valid",   out_valid,   1'b1);
        stall = 6'b101111;
        tick();
        check("ign_bub_valid",  out_valid,  1'b0);
        check("ign_bub_bubble", bubble_cnt, 16'd2);

        stall      = 6'b000000;
        in_payload = 128'h42;
        tick();
        check("pre_flush_valid", out_valid, 1'b1);
        flush   = 1'b1;
        stall   = 6'b011000;
        carry_i = 64'h5;
        tick();
        check("flush_valid",   out_valid,   1'b0);
        check("flush_payload", out_payload, 128'h0);
        check("flush_carry",   carry_o,     64'h0);
        check("flush_bubble",  bubble_cnt,  16'd2);
        stall = 6'b001000;
        tick();
        check("flush_bub_bubble", bubble_cnt, 16'd2);
        check("flush_bub_cnt",    cnt_o,      2'd0);

        flush      = 1'b0;
        stall      = 6'b000000;
        in_payload = 128'h33;
        tick();
        stall = 6'b011000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("sat_hold", hold_cnt,      (k >= HOLD_MAX) ? 3'd4 : 3'(k));
            check("sat_ovf",  hold_overflow, (k >= HOLD_MAX) ? 1'b1 : 1'b0);
        end
        check("sat_payload", out_payload, 128'h33);
        flush = 1'b1;
        tick();
        check("sat_flush_hold", hold_cnt,      3'd0);
        check("sat_flush_ovf",  hold_overflow, 1'b1);
        flush = 1'b0;
        stall = 6'b000000;
        tick();
        check("sat_adv_ovf", hold_overflow, 1'b1);

        stall = 6'b001000;
        tick();
        tick();
        tick();
        check("bub5", bubble_cnt, 16'd5);
        stall      = 6'b000000;
        in_payload = 128'h66;
        tick();
        stall   = 6'b011000;
        carry_i = 64'h9;
        cnt_i   = 2'd3;
        tick();
        tick();
        check("mid_hold_cnt", hold_cnt, 3'd2);
        rst = 1'b1;
        tick();
        check("mr_valid",   out_valid,     1'b0);
        check("mr_payload", out_payload,   128'h0);
        check("mr_carry",   carry_o,       64'h0);
        check("mr_cnt",     cnt_o,         2'd0);
        check("mr_bubble",  bubble_cnt,    16'd0);
        check("mr_hold",    hold_cnt,      3'd0);
        check("mr_ovf",     hold_overflow, 1'b0);

        rst        = 1'b0;
        stall      = 6'b000000;
        in_payload = P_A5;
        tick();
        check("post_rst_payload", out_payload, P_A5);
        check("post_rst_valid",   out_valid,   1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
